// File: rtl/async_tx_bridge_if.sv
// async_tx_bridge_if: upstream valid/ready stream plus downstream four-phase bundled-data channel
interface async_tx_bridge_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             req_out;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  modport master (output in_valid, in_data, ack_in, input in_ready, req_out, data_out);
  modport slave (input in_valid, in_data, ack_in, output in_ready, req_out, data_out);
endinterface

// File: rtl/async_tx_bridge.sv
// async_tx_bridge: FIFO-buffered clocked-to-four-phase sender; TX_BRIDGE_TIMEOUT_EN adds a sticky handshake watchdog
module async_tx_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  async_tx_bridge_if.slave   bus,
  output logic               busy,
  output logic               err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = SETUP_CYC > 1 ? $clog2(SETUP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;
  state_t                 state;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [SYNC_STAGES-1:0] sync;
  logic [SW-1:0]          setup_cnt;
  logic                   ack_s, push, pop;
  assign ack_s       = sync[SYNC_STAGES-1];
  assign bus.in_ready = count < (AW+1)'(DEPTH);
  assign push        = bus.in_valid && bus.in_ready;
  assign pop         = state == IDLE && count != '0;
  assign busy        = state != IDLE || count != '0;
  // ack_in crosses in asynchronously; only the last flop is used
  always_ff @(posedge clk)
    sync <= !rst_n ? '0 : {sync[SYNC_STAGES-2:0], bus.ack_in};
  // FIFO storage; stale contents are harmless since pointers reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_data;
  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  // four-phase handshake sequencer with registered req_out/data_out
  always_ff @(posedge clk)
    if (!rst_n) begin
      state        <= IDLE;
      bus.req_out  <= 1'b0;
      bus.data_out <= '0;
      setup_cnt    <= '0;
    end else begin
      case (state)
        IDLE:
          if (pop) begin
            bus.data_out <= mem[rd_ptr];
            setup_cnt    <= SW'(SETUP_CYC - 1);
            state        <= SETUP;
          end
        SETUP:
          if (setup_cnt == '0) begin
            bus.req_out <= 1'b1;
            state       <= REQ_HI;
          end else setup_cnt <= setup_cnt - 1'b1;
        REQ_HI:
          if (ack_s) begin
            bus.req_out <= 1'b0;
            state       <= REQ_LO;
          end
        default:
          if (!ack_s) state <= IDLE;
      endcase
    end
`ifdef TX_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo;
  logic          waiting, entering;
  assign waiting  = state == REQ_HI || state == REQ_LO;
  assign entering = (state == SETUP && setup_cnt == '0) || (state == REQ_HI && ack_s);
  // watchdog restarts on each handshake phase and saturates at TIMEOUT; err is sticky
  always_ff @(posedge clk)
    if (!rst_n) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      if (entering) tmo <= '0;
      else if (waiting && tmo != TW'(TIMEOUT)) tmo <= tmo + 1'b1;
      if (!entering && waiting && tmo == TW'(TIMEOUT - 1)) err <= 1'b1;
    end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_async_tx_bridge.sv
// tb_async_tx_bridge: random-stimulus scoreboard bench with a behavioural four-phase downstream stage
module tb_async_tx_bridge;
`ifdef TX_BRIDGE_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 255;
`endif
  logic clk = 0;
  logic rst_n;
  logic busy, err;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];
  logic ack_auto = 0;
  int   ack_lo = 0, ack_hi = 0, ack_dly = 0;
  async_tx_bridge_if #(.WIDTH(8)) bus ();
  async_tx_bridge #(.WIDTH(8), .DEPTH(4), .SETUP_CYC(1), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // downstream stage: follows req_out with ack_in after a random number of cycles
  initial begin
    int wait_cnt = 0;
    bus.ack_in = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.ack_in = 0;
        wait_cnt = 0;
      end else if (ack_auto && bus.req_out != bus.ack_in) begin
        if (wait_cnt >= ack_dly) begin
          bus.ack_in = bus.req_out;
          wait_cnt = 0;
          ack_dly = $urandom_range(ack_hi, ack_lo);
        end else wait_cnt++;
      end
    end
  end
  // scoreboard: each request must carry the next pushed word, set up early and held to release
  initial begin
    logic       prev_req = 0;
    logic [7:0] prev_data = 0, held = 0, exp;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_req = 0;
      else begin
        if (bus.req_out && !prev_req) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("order", bus.data_out, exp);
          end
          check("setup", bus.data_out, prev_data);
          held = bus.data_out;
        end
        if (!bus.req_out && prev_req) check("hold", bus.data_out, held);
        prev_req = bus.req_out;
      end
      prev_data = bus.data_out;
    end
  end
  task automatic set_ack(input logic on, input int lo, input int hi);
    ack_lo = lo;
    ack_hi = hi;
    ack_dly = $urandom_range(hi, lo);
    ack_auto = on;
  endtask
  task automatic push(input logic [7:0] w);
    int n = 0;
    bus.in_valid = 1;
    bus.in_data = w;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("push_timeout", 0, 1);
      bus.in_valid = 0;
    end else begin
      exp_q.push_back(w);
      @(negedge clk);
      bus.in_valid = 0;
    end
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0 || bus.ack_in) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, busy, 0);
    check({tag, "_all_sent"}, exp_q.size(), 0);
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.req_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, bus.req_out, 1);
  endtask
  task automatic do_reset(input string tag);
    rst_n = 0;
    @(negedge clk);
    check({tag, "_req"}, bus.req_out, 0);
    check({tag, "_data"}, bus.data_out, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    exp_q.delete();
    rst_n = 1;
  endtask
  initial begin
    int n;
    rst_n = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (2) @(negedge clk);
    do_reset("rst0");
    // single word, downstream answers 3 cycles after each edge
    set_ack(1, 3, 3);
    @(negedge clk);
    push(8'hA5);
    check("t1_not_loaded", bus.data_out, 8'h00);
    @(negedge clk);
    check("t1_load", bus.data_out, 8'hA5);
    check("t1_req_low", bus.req_out, 0);
    @(negedge clk);
    check("t1_req_high", bus.req_out, 1);
    drain("t1");
    check("t1_err", err, 0);
    // stalled downstream: one word in data_out plus four stored, then held off
    set_ack(0, 0, 0);
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("t2_full", bus.in_ready, 0);
    repeat (10) @(negedge clk);
    check("t2_held_off", bus.in_ready, 0);
    check("t2_first_out", bus.data_out, 8'h10);
    set_ack(1, 1, 1);
    push(8'h15);
    drain("t2");
    do_reset("rst1");
    // random traffic with overlapping push/pop and pointer wrap
    set_ack(1, 0, 3);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      push(8'($urandom));
    end
    drain("t3");
    // reset in the middle of a request
    set_ack(0, 0, 0);
    push(8'h77);
    push(8'h88);
    push(8'h99);
    wait_req("t4");
    @(negedge clk);
    do_reset("t4_rst");
    repeat (20) @(negedge clk);
    check("t4_no_stale_req", bus.req_out, 0);
    check("t4_idle", busy, 0);
    // watchdog with ack held low
    push(8'h3C);
    wait_req("t5");
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifdef TX_BRIDGE_TIMEOUT_EN
    check("t5_tmo_cycles", n, 20);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", err, 1);
`else
    check("t5_err_off", err, 0);
`endif
    do_reset("rst2");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
